// File: rtl/ls_buffer_pkg.sv
// Shared widths, load/store op ids and the queue entry layout for the load/store buffer.
package ls_buffer_pkg;

    localparam int OP_ID_W  = 6;
    localparam int ROB_ID_W = 5;
    localparam int DATA_W   = 32;
    localparam int IMM_W    = 32;

    localparam logic [OP_ID_W-1:0] OP_LB  = 6'd0;
    localparam logic [OP_ID_W-1:0] OP_LH  = 6'd1;
    localparam logic [OP_ID_W-1:0] OP_LW  = 6'd2;
    localparam logic [OP_ID_W-1:0] OP_LBU = 6'd3;
    localparam logic [OP_ID_W-1:0] OP_LHU = 6'd4;
    localparam logic [OP_ID_W-1:0] OP_SB  = 6'd5;
    localparam logic [OP_ID_W-1:0] OP_SH  = 6'd6;
    localparam logic [OP_ID_W-1:0] OP_SW  = 6'd7;

    typedef struct packed {
        logic                busy;
        logic [OP_ID_W-1:0]  op_id;
        logic [DATA_W-1:0]   pc;
        logic [IMM_W-1:0]    imm;
        logic [ROB_ID_W-1:0] rob_id;
        logic                q1_rdy;
        logic [DATA_W-1:0]   v1;
        logic [ROB_ID_W-1:0] t1;
        logic                q2_rdy;
        logic [DATA_W-1:0]   v2;
        logic [ROB_ID_W-1:0] t2;
    } lsb_entry_t;

endpackage

// File: rtl/ls_buffer_operand_snoop.sv
// Resolves one pending operand against both result buses; the ALU bus wins on a double hit.
module lsb_operand_snoop
    import ls_buffer_pkg::*;
(
    input  logic                rdy_i,
    input  logic [ROB_ID_W-1:0] tag_i,
    input  logic [DATA_W-1:0]   val_i,
    input  logic                alu_valid_i,
    input  logic [ROB_ID_W-1:0] alu_tag_i,
    input  logic [DATA_W-1:0]   alu_val_i,
    input  logic                ls_valid_i,
    input  logic [ROB_ID_W-1:0] ls_tag_i,
    input  logic [DATA_W-1:0]   ls_val_i,
    output logic                rdy_o,
    output logic [DATA_W-1:0]   val_o
);

    always_comb begin
        rdy_o = rdy_i;
        val_o = val_i;
        if (!rdy_i) begin
            if (alu_valid_i && (alu_tag_i == tag_i)) begin
                rdy_o = 1'b1;
                val_o = alu_val_i;
            end else if (ls_valid_i && (ls_tag_i == tag_i)) begin
                rdy_o = 1'b1;
                val_o = ls_val_i;
            end
        end
    end

endmodule

// File: rtl/ls_buffer.sv
// In-order load/store reservation queue feeding ALU_LS, one op in flight at a time.
module ls_buffer
    import ls_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [OP_ID_W-1:0]  issue_op_id,
    input  logic [DATA_W-1:0]   issue_pc,
    input  logic [DATA_W-1:0]   issue_rs1_val,
    input  logic                issue_rs1_rdy,
    input  logic [ROB_ID_W-1:0] issue_rs1_tag,
    input  logic [DATA_W-1:0]   issue_rs2_val,
    input  logic                issue_rs2_rdy,
    input  logic [ROB_ID_W-1:0] issue_rs2_tag,
    input  logic [IMM_W-1:0]    issue_imm,
    input  logic [ROB_ID_W-1:0] issue_rob_id,
    output logic                lsb_full,
    input  logic                alu_cdb_valid,
    input  logic [ROB_ID_W-1:0] alu_cdb_rob_id,
    input  logic [DATA_W-1:0]   alu_cdb_value,
    input  logic                ls_cdb_valid,
    input  logic [ROB_ID_W-1:0] ls_cdb_rob_id,
    input  logic [DATA_W-1:0]   ls_cdb_value,
    input  logic                rob_flush,
    input  logic                alu_ls_enable,
    output logic                alu_ls_valid,
    output logic [OP_ID_W-1:0]  alu_ls_op_id,
    output logic [DATA_W-1:0]   alu_ls_pc,
    output logic [DATA_W-1:0]   alu_ls_rs1,
    output logic [DATA_W-1:0]   alu_ls_rs2,
    output logic [IMM_W-1:0]    alu_ls_imm,
    output logic [ROB_ID_W-1:0] alu_ls_rob_id
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_HIGH = (PTR_W+1)'(DEPTH - 1);

    lsb_entry_t          ent_q [DEPTH];
    lsb_entry_t          ent_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                outst_q, outst_d;
    logic [ROB_ID_W-1:0] outst_rob_q, outst_rob_d;
    logic                valid_q, valid_d;
    logic [OP_ID_W-1:0]  op_q, op_d;
    logic [DATA_W-1:0]   pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IMM_W-1:0]    imm_q, imm_d;
    logic [ROB_ID_W-1:0] rob_q, rob_d;

    logic [DEPTH-1:0]    s1_rdy, s2_rdy;
    logic [DATA_W-1:0]   s1_val [DEPTH];
    logic [DATA_W-1:0]   s2_val [DEPTH];
    logic                b1_rdy, b2_rdy;
    logic [DATA_W-1:0]   b1_val, b2_val;
    logic                issue_acc, out_clear, dispatch;
    lsb_entry_t          new_entry;

    for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
        lsb_operand_snoop u_s1 (
            .rdy_i(ent_q[g].q1_rdy), .tag_i(ent_q[g].t1), .val_i(ent_q[g].v1),
            .alu_valid_i(alu_cdb_valid), .alu_tag_i(alu_cdb_rob_id), .alu_val_i(alu_cdb_value),
            .ls_valid_i(ls_cdb_valid), .ls_tag_i(ls_cdb_rob_id), .ls_val_i(ls_cdb_value),
            .rdy_o(s1_rdy[g]), .val_o(s1_val[g])
        );
        lsb_operand_snoop u_s2 (
            .rdy_i(ent_q[g].q2_rdy), .tag_i(ent_q[g].t2), .val_i(ent_q[g].v2),
            .alu_valid_i(alu_cdb_valid), .alu_tag_i(alu_cdb_rob_id), .alu_val_i(alu_cdb_value),
            .ls_valid_i(ls_cdb_valid), .ls_tag_i(ls_cdb_rob_id), .ls_val_i(ls_cdb_value),
            .rdy_o(s2_rdy[g]), .val_o(s2_val[g])
        );
    end

    // Same-cycle bypass for the operands arriving with the issue itself.
    lsb_operand_snoop u_byp1 (
        .rdy_i(issue_rs1_rdy), .tag_i(issue_rs1_tag), .val_i(issue_rs1_val),
        .alu_valid_i(alu_cdb_valid), .alu_tag_i(alu_cdb_rob_id), .alu_val_i(alu_cdb_value),
        .ls_valid_i(ls_cdb_valid), .ls_tag_i(ls_cdb_rob_id), .ls_val_i(ls_cdb_value),
        .rdy_o(b1_rdy), .val_o(b1_val)
    );
    lsb_operand_snoop u_byp2 (
        .rdy_i(issue_rs2_rdy), .tag_i(issue_rs2_tag), .val_i(issue_rs2_val),
        .alu_valid_i(alu_cdb_valid), .alu_tag_i(alu_cdb_rob_id), .alu_val_i(alu_cdb_value),
        .ls_valid_i(ls_cdb_valid), .ls_tag_i(ls_cdb_rob_id), .ls_val_i(ls_cdb_value),
        .rdy_o(b2_rdy), .val_o(b2_val)
    );

    assign lsb_full = (count_q >= CNT_HIGH);

    always_comb begin
        issue_acc = issue_valid && (count_q != CNT_MAX);
        out_clear = outst_q && ls_cdb_valid && (ls_cdb_rob_id == outst_rob_q);
        // Head readiness is taken from stored flags only, so a CDB hit costs one cycle.
        dispatch  = ent_q[head_q].busy && ent_q[head_q].q1_rdy && ent_q[head_q].q2_rdy &&
                    alu_ls_enable && !(outst_q && !out_clear) && !rob_flush;

        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.op_id  = issue_op_id;
        new_entry.pc     = issue_pc;
        new_entry.imm    = issue_imm;
        new_entry.rob_id = issue_rob_id;
        new_entry.q1_rdy = b1_rdy;
        new_entry.v1     = b1_val;
        new_entry.t1     = issue_rs1_tag;
        new_entry.q2_rdy = b2_rdy;
        new_entry.v2     = b2_val;
        new_entry.t2     = issue_rs2_tag;

        ent_d       = ent_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        outst_d     = outst_q && !out_clear;
        outst_rob_d = outst_rob_q;
        valid_d     = 1'b0;
        op_d        = op_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        imm_d       = imm_q;
        rob_d       = rob_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].busy) begin
                ent_d[i].q1_rdy = s1_rdy[i];
                ent_d[i].v1     = s1_val[i];
                ent_d[i].q2_rdy = s2_rdy[i];
                ent_d[i].v2     = s2_val[i];
            end
        end

        // The in-flight ALU_LS op survives a flush, so outstanding is left alone here.
        if (rob_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].busy = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_acc) begin
                ent_d[tail_q] = new_entry;
                tail_d        = tail_q + PTR_ONE;
            end
            if (dispatch) begin
                ent_d[head_q].busy = 1'b0;
                head_d      = head_q + PTR_ONE;
                outst_d     = 1'b1;
                outst_rob_d = ent_q[head_q].rob_id;
                valid_d     = 1'b1;
                op_d        = ent_q[head_q].op_id;
                pc_d        = ent_q[head_q].pc;
                rs1_d       = ent_q[head_q].v1;
                rs2_d       = ent_q[head_q].v2;
                imm_d       = ent_q[head_q].imm;
                rob_d       = ent_q[head_q].rob_id;
            end
            case ({issue_acc, dispatch})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            outst_q     <= 1'b0;
            outst_rob_q <= '0;
            valid_q     <= 1'b0;
            op_q        <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rob_q       <= '0;
        end else if (rdy) begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            outst_q     <= outst_d;
            outst_rob_q <= outst_rob_d;
            valid_q     <= valid_d;
            op_q        <= op_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            rob_q       <= rob_d;
        end
    end

    assign alu_ls_valid  = valid_q;
    assign alu_ls_op_id  = op_q;
    assign alu_ls_pc     = pc_q;
    assign alu_ls_rs1    = rs1_q;
    assign alu_ls_rs2    = rs2_q;
    assign alu_ls_imm    = imm_q;
    assign alu_ls_rob_id = rob_q;

endmodule

// File: tb/tb_ls_buffer.sv
// Scoreboarded bench for ls_buffer: expected dispatches are queued at issue and popped on each pulse.
module tb_ls_buffer;
    import ls_buffer_pkg::*;

    localparam int EW = OP_ID_W + 4 * DATA_W + ROB_ID_W;

    logic                clk = 1'b0;
    logic                rst, rdy;
    logic                issue_valid;
    logic [OP_ID_W-1:0]  issue_op_id;
    logic [DATA_W-1:0]   issue_pc, issue_rs1_val, issue_rs2_val;
    logic                issue_rs1_rdy, issue_rs2_rdy;
    logic [ROB_ID_W-1:0] issue_rs1_tag, issue_rs2_tag, issue_rob_id;
    logic [IMM_W-1:0]    issue_imm;
    logic                lsb_full;
    logic                alu_cdb_valid, ls_cdb_valid;
    logic [ROB_ID_W-1:0] alu_cdb_rob_id, ls_cdb_rob_id;
    logic [DATA_W-1:0]   alu_cdb_value, ls_cdb_value;
    logic                rob_flush, alu_ls_enable;
    logic                alu_ls_valid;
    logic [OP_ID_W-1:0]  alu_ls_op_id;
    logic [DATA_W-1:0]   alu_ls_pc, alu_ls_rs1, alu_ls_rs2;
    logic [IMM_W-1:0]    alu_ls_imm;
    logic [ROB_ID_W-1:0] alu_ls_rob_id;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    ls_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_op_id(issue_op_id), .issue_pc(issue_pc),
        .issue_rs1_val(issue_rs1_val), .issue_rs1_rdy(issue_rs1_rdy), .issue_rs1_tag(issue_rs1_tag),
        .issue_rs2_val(issue_rs2_val), .issue_rs2_rdy(issue_rs2_rdy), .issue_rs2_tag(issue_rs2_tag),
        .issue_imm(issue_imm), .issue_rob_id(issue_rob_id), .lsb_full(lsb_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id), .alu_cdb_value(alu_cdb_value),
        .ls_cdb_valid(ls_cdb_valid), .ls_cdb_rob_id(ls_cdb_rob_id), .ls_cdb_value(ls_cdb_value),
        .rob_flush(rob_flush), .alu_ls_enable(alu_ls_enable),
        .alu_ls_valid(alu_ls_valid), .alu_ls_op_id(alu_ls_op_id), .alu_ls_pc(alu_ls_pc),
        .alu_ls_rs1(alu_ls_rs1), .alu_ls_rs2(alu_ls_rs2), .alu_ls_imm(alu_ls_imm),
        .alu_ls_rob_id(alu_ls_rob_id)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_issue(input logic [OP_ID_W-1:0] op, input logic [DATA_W-1:0] pc,
                            input logic [DATA_W-1:0] rs1, input logic r1, input logic [ROB_ID_W-1:0] t1,
                            input logic [DATA_W-1:0] rs2, input logic r2, input logic [ROB_ID_W-1:0] t2,
                            input logic [IMM_W-1:0] imm, input logic [ROB_ID_W-1:0] rob);
        issue_op_id   = op;
        issue_pc      = pc;
        issue_rs1_val = rs1;
        issue_rs1_rdy = r1;
        issue_rs1_tag = t1;
        issue_rs2_val = rs2;
        issue_rs2_rdy = r2;
        issue_rs2_tag = t2;
        issue_imm     = imm;
        issue_rob_id  = rob;
        issue_valid   = 1'b1;
        tick();
        issue_valid   = 1'b0;
    endtask

    task automatic push_exp(input logic [OP_ID_W-1:0] op, input logic [DATA_W-1:0] pc,
                            input logic [DATA_W-1:0] rs1, input logic [DATA_W-1:0] rs2,
                            input logic [IMM_W-1:0] imm, input logic [ROB_ID_W-1:0] rob);
        exp_q.push_back({op, pc, rs1, rs2, imm, rob});
    endtask

    task automatic send_ls(input logic [ROB_ID_W-1:0] rob, input logic [DATA_W-1:0] val);
        ls_cdb_valid  = 1'b1;
        ls_cdb_rob_id = rob;
        ls_cdb_value  = val;
        tick();
        ls_cdb_valid  = 1'b0;
    endtask

    task automatic send_alu(input logic [ROB_ID_W-1:0] rob, input logic [DATA_W-1:0] val);
        alu_cdb_valid  = 1'b1;
        alu_cdb_rob_id = rob;
        alu_cdb_value  = val;
        tick();
        alu_cdb_valid  = 1'b0;
    endtask

    // Returns each dispatched op in turn so the next one may go.
    task automatic drain(input int n);
        logic [ROB_ID_W-1:0] r;
        int budget;
        for (int k = 0; k < n; k++) begin
            budget = 8;
            while (!alu_ls_valid && budget > 0) begin
                tick();
                budget--;
            end
            total++;
            if (!alu_ls_valid) begin
                bad++;
                $display("FAIL drain_timeout: no dispatch for op %0d of %0d, required a pulse", k, n);
                return;
            end
            r = alu_ls_rob_id;
            send_ls(r, 32'h0);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && alu_ls_valid) begin
            logic [EW-1:0] got, expv;
            got = {alu_ls_op_id, alu_ls_pc, alu_ls_rs1, alu_ls_rs2, alu_ls_imm, alu_ls_rob_id};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_dispatch: got rob %0d, required no dispatch", alu_ls_rob_id);
            end else begin
                expv = exp_q.pop_front();
                if (got !== expv) begin
                    bad++;
                    $display("FAIL dispatch_data: got %h required %h", got, expv);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b required 0", alu_ls_valid); end
        total++; if (lsb_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b required 0", lsb_full); end
        total++; if (alu_ls_rs1 !== '0) begin bad++; $display("FAIL reset_rs1: got %h required 0", alu_ls_rs1); end
        total++; if (alu_ls_pc !== '0) begin bad++; $display("FAIL reset_pc: got %h required 0", alu_ls_pc); end
        total++; if (alu_ls_rob_id !== '0) begin bad++; $display("FAIL reset_rob: got %0d required 0", alu_ls_rob_id); end
    endtask

    task automatic test_basic();
        push_exp(OP_LW, 32'h100, 32'h1000, 32'h0, 32'd4, 5'd3);
        do_issue(OP_LW, 32'h100, 32'h1000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd4, 5'd3);
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got %b required 0", alu_ls_valid); end
        tick();
        total++; if (alu_ls_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: got %b required 1", alu_ls_valid); end
        total++; if (alu_ls_rob_id !== 5'd3) begin bad++; $display("FAIL basic_rob: got %0d required 3", alu_ls_rob_id); end
        push_exp(OP_LW, 32'h104, 32'h1100, 32'h0, 32'd0, 5'd4);
        do_issue(OP_LW, 32'h104, 32'h1100, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, 5'd4);
        for (int i = 0; i < 3; i++) begin
            total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL basic_outstanding: got %b required 0 at %0d", alu_ls_valid, i); end
            tick();
        end
        send_ls(5'd3, 32'h0);
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rob_id !== 5'd4) begin
            bad++; $display("FAIL basic_release: got valid %b rob %0d required 1 rob 4", alu_ls_valid, alu_ls_rob_id);
        end
        send_ls(5'd4, 32'h0);
    endtask

    task automatic test_store_late();
        push_exp(OP_SW, 32'h200, 32'h2000, 32'hDEADBEEF, 32'd8, 5'd6);
        do_issue(OP_SW, 32'h200, 32'h2000, 1'b1, 5'd0, 32'h0, 1'b0, 5'd5, 32'd8, 5'd6);
        tick();
        send_alu(5'd5, 32'hDEADBEEF);
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL store_early: got %b required 0", alu_ls_valid); end
        tick();
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rs2 !== 32'hDEADBEEF) begin
            bad++; $display("FAIL store_rs2: got valid %b rs2 %h required 1 deadbeef", alu_ls_valid, alu_ls_rs2);
        end
        send_ls(5'd6, 32'h0);
    endtask

    task automatic test_in_order();
        push_exp(OP_LW, 32'h300, 32'h55, 32'h0, 32'd0, 5'd8);
        push_exp(OP_LW, 32'h304, 32'h3000, 32'h0, 32'd12, 5'd9);
        do_issue(OP_LW, 32'h300, 32'h0, 1'b0, 5'd7, 32'h0, 1'b1, 5'd0, 32'd0, 5'd8);
        do_issue(OP_LW, 32'h304, 32'h3000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd12, 5'd9);
        for (int i = 0; i < 2; i++) begin
            total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL order_bypass: got %b required 0", alu_ls_valid); end
            tick();
        end
        send_ls(5'd7, 32'h55);
        tick();
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rob_id !== 5'd8) begin
            bad++; $display("FAIL order_head: got valid %b rob %0d required 1 rob 8", alu_ls_valid, alu_ls_rob_id);
        end
        tick();
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL order_young_early: got %b required 0", alu_ls_valid); end
        send_ls(5'd8, 32'h0);
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rob_id !== 5'd9) begin
            bad++; $display("FAIL order_young: got valid %b rob %0d required 1 rob 9", alu_ls_valid, alu_ls_rob_id);
        end
        send_ls(5'd9, 32'h0);
    endtask

    task automatic test_issue_bypass();
        push_exp(OP_LW, 32'h400, 32'h80, 32'h0, 32'd0, 5'd12);
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 5'd2; alu_cdb_value = 32'h80;
        do_issue(OP_LW, 32'h400, 32'h0, 1'b0, 5'd2, 32'h0, 1'b1, 5'd0, 32'd0, 5'd12);
        alu_cdb_valid = 1'b0;
        tick();
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rs1 !== 32'h80) begin
            bad++; $display("FAIL bypass_alu: got valid %b rs1 %h required 1 80", alu_ls_valid, alu_ls_rs1);
        end
        send_ls(5'd12, 32'h0);
        push_exp(OP_SW, 32'h404, 32'h4000, 32'h77, 32'd16, 5'd13);
        ls_cdb_valid = 1'b1; ls_cdb_rob_id = 5'd4; ls_cdb_value = 32'h77;
        do_issue(OP_SW, 32'h404, 32'h4000, 1'b1, 5'd0, 32'h0, 1'b0, 5'd4, 32'd16, 5'd13);
        ls_cdb_valid = 1'b0;
        tick();
        total++; if (alu_ls_valid !== 1'b1 || alu_ls_rs2 !== 32'h77) begin
            bad++; $display("FAIL bypass_ls: got valid %b rs2 %h required 1 77", alu_ls_valid, alu_ls_rs2);
        end
        send_ls(5'd13, 32'h0);
    endtask

    task automatic test_rdy_freeze();
        rdy = 1'b0;
        do_issue(OP_LB, 32'h500, 32'h5000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, 5'd14);
        tick();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL freeze_issue: got %b required 0", alu_ls_valid); end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        alu_ls_enable = 1'b0;
        for (int i = 0; i < 15; i++) begin
            push_exp(OP_LW, 32'h1000 + 32'(4 * i), 32'(i * 256), 32'h0, 32'(i), ROB_ID_W'(16 + i));
            do_issue(OP_LW, 32'h1000 + 32'(4 * i), 32'(i * 256), 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'(i), ROB_ID_W'(16 + i));
            if (i == 13) begin
                total++; if (lsb_full !== 1'b0) begin bad++; $display("FAIL full_at14: got %b required 0", lsb_full); end
            end
        end
        total++; if (lsb_full !== 1'b1) begin bad++; $display("FAIL full_at15: got %b required 1", lsb_full); end
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL full_stalled: got %b required 0", alu_ls_valid); end
        alu_ls_enable = 1'b1;
        push_exp(OP_SB, 32'h2000, 32'hABCD, 32'h12, 32'd1, 5'd31);
        do_issue(OP_SB, 32'h2000, 32'hABCD, 1'b1, 5'd0, 32'h12, 1'b1, 5'd0, 32'd1, 5'd31);
        total++; if (alu_ls_valid !== 1'b1) begin bad++; $display("FAIL full_dispatch: got %b required 1", alu_ls_valid); end
        total++; if (lsb_full !== 1'b1) begin bad++; $display("FAIL full_count_hold: got %b required 1", lsb_full); end
        drain(16);
        total++; if (lsb_full !== 1'b0) begin bad++; $display("FAIL full_drained: got %b required 0", lsb_full); end
    endtask

    task automatic test_flush();
        do_reset();
        push_exp(OP_LW, 32'h600, 32'h6000, 32'h0, 32'd0, 5'd1);
        do_issue(OP_LW, 32'h600, 32'h6000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, 5'd1);
        for (int i = 0; i < 6; i++) begin
            do_issue(OP_LW, 32'h700, 32'h7000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, ROB_ID_W'(2 + i));
        end
        rob_flush = 1'b1;
        do_issue(OP_LW, 32'h800, 32'h8000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, 5'd9);
        rob_flush = 1'b0;
        total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b required 0", alu_ls_valid); end
        push_exp(OP_LHU, 32'h900, 32'h9000, 32'h0, 32'd2, 5'd10);
        do_issue(OP_LHU, 32'h900, 32'h9000, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd2, 5'd10);
        for (int i = 0; i < 3; i++) begin
            total++; if (alu_ls_valid !== 1'b0) begin bad++; $display("FAIL flush_outstanding: got %b required 0", alu_ls_valid); end
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            push_exp(OP_LH, 32'hA00 + 32'(i), 32'h0, 32'h0, 32'd0, ROB_ID_W'(11 + i));
            do_issue(OP_LH, 32'hA00 + 32'(i), 32'h0, 1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'd0, ROB_ID_W'(11 + i));
            if (i == 12) begin
                total++; if (lsb_full !== 1'b0) begin bad++; $display("FAIL flush_count14: got %b required 0", lsb_full); end
            end
        end
        total++; if (lsb_full !== 1'b1) begin bad++; $display("FAIL flush_count15: got %b required 1", lsb_full); end
        send_ls(5'd1, 32'h0);
        drain(15);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; issue_valid = 1'b0;
        issue_op_id = '0; issue_pc = '0; issue_rs1_val = '0; issue_rs1_rdy = 1'b0; issue_rs1_tag = '0;
        issue_rs2_val = '0; issue_rs2_rdy = 1'b0; issue_rs2_tag = '0; issue_imm = '0; issue_rob_id = '0;
        alu_cdb_valid = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
        ls_cdb_valid = 1'b0; ls_cdb_rob_id = '0; ls_cdb_value = '0;
        rob_flush = 1'b0; alu_ls_enable = 1'b1;
        do_reset();
        test_reset();
        test_basic();
        test_store_late();
        test_in_order();
        test_issue_bypass();
        test_rdy_freeze();
        test_full();
        test_flush();
        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
